// File: rtl/rv_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses, cause codes,
// mstatus/mie bit positions and the synchronous-exception payload.
package rv_trap_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CSR_AW    = 12;
  localparam int unsigned CAUSE_W   = 5;

  typedef enum logic [CSR_AW-1:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MIE     = 12'h304,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MIP     = 12'h344
  } csr_addr_e;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSN   = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT     = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_UNALIGNED_LOAD = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_UNALIGNED_STORE = 5'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER_IRQ      = 5'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL          = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_EXT_IRQ_BASE   = 5'd16;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_TIMER_BIT    = 7;
  localparam int unsigned MIE_IRQ_BASE     = 16;

  typedef struct packed {
    logic invalid_insn;
    logic breakpoint;
    logic unaligned_load;
    logic unaligned_store;
    logic ecall;
  } sync_exc_t;

  // Encoder slot 0 is the timer, slot k+1 is external line k.
  function automatic logic [CAUSE_W-1:0] irq_cause(input logic [CAUSE_W-1:0] slot);
    return (slot == '0) ? CAUSE_TIMER_IRQ
                        : CAUSE_W'(slot + CAUSE_EXT_IRQ_BASE - 5'd1);
  endfunction

endpackage

// File: rtl/rv_trap_ctrl_if.sv
// Execute-stage <-> trap controller bus: instruction context in, trap/return redirect out.
interface rv_trap_ctrl_if;
  import rv_trap_ctrl_pkg::*;

  logic                x_stall;
  logic                x_kill;
  logic                d_is_csr;
  logic                d_is_mret;
  logic [CSR_AW-1:0]   d_csr_sel;
  logic [XLEN-1:0]     x_csr_write_value;
  logic [XLEN-1:0]     x_pc;
  sync_exc_t           exc;
  logic                x_trap;
  logic                x_mret;
  logic [XLEN-1:0]     x_redirect_pc;

  modport master (
    output x_stall, x_kill, d_is_csr, d_is_mret, d_csr_sel, x_csr_write_value, x_pc, exc,
    input  x_trap, x_mret, x_redirect_pc
  );

  modport slave (
    input  x_stall, x_kill, d_is_csr, d_is_mret, d_csr_sel, x_csr_write_value, x_pc, exc,
    output x_trap, x_mret, x_redirect_pc
  );
endinterface

// File: rtl/rv_irq_prio_enc.sv
// Lowest-index-wins priority encoder with valid flag and 5-bit winning index.
module rv_irq_prio_enc #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [4:0]   idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap controller: sync exception / timer / external IRQ prioritisation,
// mepc/mcause/mstatus bookkeeping and MRET. Define URV_VECTORED_TRAP_EN for vectored interrupts.
module rv_trap_ctrl
  import rv_trap_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [31:0] TRAP_BASE = 32'h8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rv_trap_ctrl_if.slave      x_if,
  input  logic               tick_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [XLEN-1:0]    csr_mstatus_o,
  output logic [XLEN-1:0]    csr_mie_o,
  output logic [XLEN-1:0]    csr_mip_o,
  output logic [XLEN-1:0]    csr_mepc_o,
  output logic [XLEN-1:0]    csr_mcause_o
);

  localparam int unsigned NUM_SRC = NUM_IRQ + 1;

  logic            mie_bit_q, mie_bit_d;
  logic            mpie_q, mpie_d;
  logic            timer_pend_q, timer_pend_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [XLEN-1:0]    mie_impl;
  logic [XLEN-1:0]    mip;
  logic [NUM_SRC-1:0] irq_req;
  logic               irq_valid;
  logic [4:0]         irq_slot;
  logic [4:0]         irq_code;

  logic               adv;
  logic               sync_exc;
  logic [4:0]         sync_code;
  logic               irq_take;
  logic               trap;
  logic               mret;
  logic               csr_wr;
  logic               unused_c;

  assign unused_c = ^x_if.x_pc[1:0];

  // Implemented mie bits and live pending view.
  always_comb begin
    mie_impl                = '0;
    mie_impl[MIE_TIMER_BIT] = 1'b1;
    mip                     = '0;
    mip[MIE_TIMER_BIT]      = timer_pend_q;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      mie_impl[MIE_IRQ_BASE + k] = 1'b1;
      mip[MIE_IRQ_BASE + k]      = irq_i[k];
    end
  end

  always_comb begin
    irq_req    = '0;
    irq_req[0] = timer_pend_q & mie_q[MIE_TIMER_BIT];
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      irq_req[k+1] = irq_i[k] & mie_q[MIE_IRQ_BASE + k];
    end
  end

  rv_irq_prio_enc #(.N(NUM_SRC)) u_prio_enc (
    .req_i   (irq_req),
    .valid_o (irq_valid),
    .idx_o   (irq_slot)
  );

  assign irq_code = irq_cause(irq_slot);

  always_comb begin
    sync_exc  = 1'b1;
    sync_code = CAUSE_ILLEGAL_INSN;
    if      (x_if.exc.invalid_insn)    sync_code = CAUSE_ILLEGAL_INSN;
    else if (x_if.exc.breakpoint)      sync_code = CAUSE_BREAKPOINT;
    else if (x_if.exc.unaligned_load)  sync_code = CAUSE_UNALIGNED_LOAD;
    else if (x_if.exc.unaligned_store) sync_code = CAUSE_UNALIGNED_STORE;
    else if (x_if.exc.ecall)           sync_code = CAUSE_ECALL;
    else                               sync_exc  = 1'b0;
  end

  assign adv      = !x_if.x_stall && !x_if.x_kill;
  assign irq_take = !sync_exc && mie_bit_q && !x_if.d_is_mret && irq_valid;
  assign trap     = adv && (sync_exc || irq_take);
  assign mret     = adv && x_if.d_is_mret && !sync_exc;
  assign csr_wr   = adv && x_if.d_is_csr;

  // Same-cycle redirect to fetch.
  always_comb begin
    x_if.x_trap        = trap;
    x_if.x_mret        = mret;
    x_if.x_redirect_pc = '0;
    if (trap) begin
      x_if.x_redirect_pc = TRAP_BASE;
`ifdef URV_VECTORED_TRAP_EN
      if (!sync_exc) x_if.x_redirect_pc = TRAP_BASE + {25'b0, irq_code, 2'b00};
`endif
    end else if (mret) begin
      x_if.x_redirect_pc = mepc_q;
    end
  end

  always_comb begin
    mie_bit_d    = mie_bit_q;
    mpie_d       = mpie_q;
    mie_d        = mie_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    timer_pend_d = timer_pend_q;

    if (csr_wr) begin
      case (x_if.d_csr_sel)
        CSR_MSTATUS: begin
          mie_bit_d = x_if.x_csr_write_value[MSTATUS_MIE_BIT];
          mpie_d    = x_if.x_csr_write_value[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mie_d    = x_if.x_csr_write_value & mie_impl;
        CSR_MEPC:   mepc_d   = {x_if.x_csr_write_value[31:2], 2'b00};
        CSR_MCAUSE: mcause_d = {x_if.x_csr_write_value[31], 26'b0, x_if.x_csr_write_value[4:0]};
        CSR_MIP:    if (!x_if.x_csr_write_value[MIE_TIMER_BIT]) timer_pend_d = 1'b0;
        default: ;
      endcase
    end

    // Tick always wins over a clearing write, regardless of stall/kill.
    if (tick_i) timer_pend_d = 1'b1;

    if (trap) begin
      mepc_d    = {x_if.x_pc[31:2], 2'b00};
      mcause_d  = {!sync_exc, 26'b0, sync_exc ? sync_code : irq_code};
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (mret) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_bit_q    <= 1'b0;
      mpie_q       <= 1'b0;
      timer_pend_q <= 1'b0;
      mie_q        <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      mie_bit_q    <= mie_bit_d;
      mpie_q       <= mpie_d;
      timer_pend_q <= timer_pend_d;
      mie_q        <= mie_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
    end
  end

  always_comb begin
    csr_mstatus_o                   = '0;
    csr_mstatus_o[MSTATUS_MIE_BIT]  = mie_bit_q;
    csr_mstatus_o[MSTATUS_MPIE_BIT] = mpie_q;
  end

  assign csr_mie_o    = mie_q;
  assign csr_mip_o    = mip;
  assign csr_mepc_o   = mepc_q;
  assign csr_mcause_o = mcause_q;

endmodule
